pipe_hazard_ctrl: RTL and testbench

Hazard controller for the 5-stage 8-bit pipeline (IF → L1 → ID → L2 → EX → L3 → MEM → L4 → WB). It keeps a scoreboard of in-flight register writes and stalls IF/ID when a decoded source register is still pending. It flushes the two younger stages when EX resolves a taken branch. It also drives the PC enable, L1 hold/flush and L2 bubble controls, and keeps saturating stall/flush counters plus a stall watchdog.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_hazard_ctrl_if.sv | 36 +++
 rtl/hz_scoreboard.sv | 58 +++++
 rtl/pipe_hazard_ctrl.sv | 95 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard FSM encoding, register address width and NOP controls.
// Also used by the L1/L2 pipeline registers.
package pipe_pkg;

    localparam int unsigned REG_AW = 3;

    typedef logic [REG_AW-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StStall = 2'd1,
        StFlush = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic reg_write;
        logic mem_write;
        logic mem_read;
    } l2_ctrl_t;

    localparam l2_ctrl_t NOP_CTRL = '0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID/EX hazard signals between the pipeline datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    import pipe_pkg::*;

    logic             id_valid;
    reg_addr_t        id_ra;
    reg_addr_t        id_rb;
    logic             id_use_ra;
    logic             id_use_rb;
    logic             id_regwrite;
    reg_addr_t        id_rd;
    logic             ex_branch_taken;
    logic             pc_en;
    logic             l1_en;
    logic             l1_flush;
    logic             l2_bubble;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             wdog_err;

    modport master (
        output id_valid, id_ra, id_rb, id_use_ra, id_use_rb, id_regwrite, id_rd,
               ex_branch_taken,
        input  pc_en, l1_en, l1_flush, l2_bubble, stall, stall_cnt, flush_cnt, wdog_err
    );

    modport slave (
        input  id_valid, id_ra, id_rb, id_use_ra, id_use_rb, id_regwrite, id_rd,
               ex_branch_taken,
        output pc_en, l1_en, l1_flush, l2_bubble, stall, stall_cnt, flush_cnt, wdog_err
    );

endinterface

// File: rtl/hz_scoreboard.sv
// Three-entry EX/MEM/WB shadow of pending register writes; flags a RAW hazard for the ID sources.
module hz_scoreboard
    import pipe_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      id_valid,
    input  reg_addr_t id_ra,
    input  reg_addr_t id_rb,
    input  logic      id_use_ra,
    input  logic      id_use_rb,
    input  logic      id_regwrite,
    input  reg_addr_t id_rd,
    input  logic      l2_bubble,
    output logic      hazard
);

    logic      ex_valid_q, mem_valid_q, wb_valid_q;
    reg_addr_t ex_rd_q, mem_rd_q, wb_rd_q;
    logic      ex_valid_d;

    // The register file has no write-through, so WB still counts as pending.
    function automatic logic match(input reg_addr_t r,
                                   input logic ev, input reg_addr_t er,
                                   input logic mv, input reg_addr_t mr,
                                   input logic wv, input reg_addr_t wr);
        return (ev && er == r) || (mv && mr == r) || (wv && wr == r);
    endfunction

    assign ex_valid_d = id_regwrite & id_valid & ~l2_bubble;

    always_comb begin
        hazard = id_valid &
                 ((id_use_ra & match(id_ra, ex_valid_q, ex_rd_q, mem_valid_q, mem_rd_q,
                                     wb_valid_q, wb_rd_q)) |
                  (id_use_rb & match(id_rb, ex_valid_q, ex_rd_q, mem_valid_q, mem_rd_q,
                                     wb_valid_q, wb_rd_q)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            ex_rd_q     <= '0;
            mem_rd_q    <= '0;
            wb_rd_q     <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_rd_q     <= id_rd;
            mem_valid_q <= ex_valid_q;
            mem_rd_q    <= ex_rd_q;
            wb_valid_q  <= mem_valid_q;
            wb_rd_q     <= mem_rd_q;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: RAW stall, taken-branch flush, saturating event counters and stall watchdog.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned STALL_LIMIT = 4,
    parameter int unsigned CNT_W       = 16
) (
    input logic              clk,
    input logic              rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam logic [3:0] WdLimit = 4'(STALL_LIMIT);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic [3:0]       wd_cnt_q, wd_inc;
    logic             wdog_err_q;
    logic             hazard;
    logic             pc_en, l1_en, l1_flush, l2_bubble;

    hz_scoreboard u_sb (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (bus.id_valid),
        .id_ra       (bus.id_ra),
        .id_rb       (bus.id_rb),
        .id_use_ra   (bus.id_use_ra),
        .id_use_rb   (bus.id_use_rb),
        .id_regwrite (bus.id_regwrite),
        .id_rd       (bus.id_rd),
        .l2_bubble   (l2_bubble),
        .hazard      (hazard)
    );

    // A taken branch kills the ID instruction, so its hazard is irrelevant.
    always_comb begin
        pc_en     = 1'b1;
        l1_en     = 1'b1;
        l1_flush  = 1'b0;
        l2_bubble = 1'b0;
        state_d   = StRun;
        if (bus.ex_branch_taken) begin
            l1_en     = 1'b0;
            l1_flush  = 1'b1;
            l2_bubble = 1'b1;
            state_d   = StFlush;
        end else if (hazard) begin
            pc_en     = 1'b0;
            l1_en     = 1'b0;
            l2_bubble = 1'b1;
            state_d   = StStall;
        end
    end

    assign wd_inc = wd_cnt_q + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wd_cnt_q    <= '0;
            wdog_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == StStall && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (bus.ex_branch_taken && flush_cnt_q != '1) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
            if (state_q == StStall) begin
                if (wd_cnt_q != 4'hF) begin
                    wd_cnt_q <= wd_inc;
                end
                if (wd_inc == WdLimit) begin
                    wdog_err_q <= 1'b1;
                end
            end else begin
                wd_cnt_q <= '0;
            end
        end
    end

    assign bus.pc_en     = pc_en;
    assign bus.l1_en     = l1_en;
    assign bus.l1_flush  = l1_flush;
    assign bus.l2_bubble = l2_bubble;
    assign bus.stall     = (state_q == StStall);
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
    assign bus.wdog_err  = wdog_err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, random stimulus against a queue-based model,
// and a stuck-scoreboard run covering the watchdog and counter saturation.
module tb_pipe_hazard_ctrl;
    import pipe_pkg::*;

    localparam int unsigned LIMIT = 4;
    localparam int unsigned CMAX  = 32'hFFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(16)) bus ();

    pipe_hazard_ctrl #(
        .STALL_LIMIT (LIMIT),
        .CNT_W       (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       rst;
        logic       valid;
        logic [2:0] ra;
        logic [2:0] rb;
        logic       ura;
        logic       urb;
        logic       rw;
        logic [2:0] rd;
        logic       br;
        logic       e_pc;
        logic       e_fl;
        logic       e_bub;
        logic       e_st;
        int         e_scnt;
        int         e_fcnt;
        logic [1:0] e_state;
    } vec_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] rd;
    } ent_t;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: pending writes as a queue, index 0 = youngest (EX), 2 = oldest (WB).
    ent_t        sbq[$];
    logic        wb_stuck = 1'b0;
    logic        m_stall = 1'b0, m_err = 1'b0, m_haz, m_bub;
    int unsigned m_scnt = 0, m_fcnt = 0, m_run = 0;

    function automatic vec_t v(input logic r, input logic vl, input int ra, input int rb,
                               input logic ua, input logic ub, input logic rw, input int rd,
                               input logic br, input logic pc, input logic fl, input logic bub,
                               input logic st, input int sc, input int fc, input int stt);
        vec_t t;
        t.rst = r; t.valid = vl; t.ra = 3'(ra); t.rb = 3'(rb); t.ura = ua; t.urb = ub;
        t.rw = rw; t.rd = 3'(rd); t.br = br; t.e_pc = pc; t.e_fl = fl; t.e_bub = bub;
        t.e_st = st; t.e_scnt = sc; t.e_fcnt = fc; t.e_state = 2'(stt);
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        ent_t z;
        z = '0;
        sbq = {};
        for (int i = 0; i < 3; i++) sbq.push_back(z);
        m_stall = 1'b0; m_err = 1'b0; m_scnt = 0; m_fcnt = 0; m_run = 0; wb_stuck = 1'b0;
    endtask

    function automatic logic pending(input logic [2:0] r);
        for (int i = 0; i < 3; i++) begin
            if ((sbq[i].valid || (wb_stuck && i == 2)) && sbq[i].rd == r) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic drive(input vec_t t);
        @(negedge clk);
        rst                 = t.rst;
        bus.id_valid        = t.valid;
        bus.id_ra           = t.ra;
        bus.id_rb           = t.rb;
        bus.id_use_ra       = t.ura;
        bus.id_use_rb       = t.urb;
        bus.id_regwrite     = t.rw;
        bus.id_rd           = t.rd;
        bus.ex_branch_taken = t.br;
        #1;
    endtask

    task automatic check_model();
        logic br;
        br    = bus.ex_branch_taken;
        m_haz = bus.id_valid && ((bus.id_use_ra && pending(bus.id_ra)) ||
                                 (bus.id_use_rb && pending(bus.id_rb)));
        m_bub = br || m_haz;
        chk("pc_en", 32'(bus.pc_en), 32'(br || !m_haz));
        chk("l1_flush", 32'(bus.l1_flush), 32'(br));
        chk("l2_bubble", 32'(bus.l2_bubble), 32'(m_bub));
        if (!br) chk("l1_en", 32'(bus.l1_en), 32'(!m_haz));
        chk("stall", 32'(bus.stall), 32'(m_stall));
        chk("stall_cnt", 32'(bus.stall_cnt), m_scnt);
        chk("flush_cnt", 32'(bus.flush_cnt), m_fcnt);
        chk("wdog_err", 32'(bus.wdog_err), 32'(m_err));
    endtask

    task automatic advance();
        ent_t e;
        logic nxt;
        @(posedge clk);
        cyc++;
        if (rst) begin
            model_reset();
        end else begin
            e.valid = bus.id_valid && bus.id_regwrite && !m_bub;
            e.rd    = bus.id_rd;
            sbq.push_front(e);
            void'(sbq.pop_back());
            nxt   = !bus.ex_branch_taken && m_haz;
            m_run = m_stall ? m_run + 1 : 0;
            if (m_run >= LIMIT) m_err = 1'b1;
            m_stall = nxt;
            if (nxt && m_scnt != CMAX) m_scnt++;
            if (bus.ex_branch_taken && m_fcnt != CMAX) m_fcnt++;
        end
    endtask

    vec_t tbl[$];
    vec_t t;

    initial begin
        model_reset();
        t = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        drive(t);
        @(posedge clk);
        @(posedge clk);

        //         rst vl ra rb ua ub rw rd br  pc fl bb st sc fc state
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 1, 0, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 1, 0, 1, 2, 0, 0, 0, 1, 1, 1, 0, 1));
        tbl.push_back(v(0, 1, 1, 0, 1, 0, 1, 2, 0, 0, 0, 1, 1, 2, 0, 1));
        tbl.push_back(v(0, 1, 1, 0, 1, 0, 1, 2, 0, 1, 0, 0, 1, 3, 0, 1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 1, 3, 0, 1, 0, 0, 0, 3, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3, 0, 0));
        tbl.push_back(v(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0));
        tbl.push_back(v(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 4, 0, 1));
        tbl.push_back(v(0, 1, 3, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 5, 0, 1));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 1, 4, 0, 1, 0, 0, 0, 5, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5, 0, 0));
        tbl.push_back(v(0, 1, 0, 4, 0, 1, 0, 0, 0, 0, 0, 1, 0, 5, 0, 0));
        tbl.push_back(v(0, 1, 0, 4, 0, 1, 0, 0, 0, 1, 0, 0, 1, 6, 0, 1));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 1, 5, 0, 1, 0, 0, 0, 6, 0, 0));
        tbl.push_back(v(0, 1, 6, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0, 6, 0, 0));
        tbl.push_back(v(0, 1, 5, 0, 1, 0, 0, 0, 1, 1, 1, 1, 0, 6, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6, 1, 2));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6, 1, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 1, 7, 0, 1, 0, 0, 0, 6, 1, 0));
        tbl.push_back(v(0, 1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 6, 1, 0));
        tbl.push_back(v(1, 1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 7, 1, 1));
        tbl.push_back(v(0, 1, 7, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i]);
            check_model();
            chk($sformatf("tbl%0d.pc_en", i), 32'(bus.pc_en), 32'(tbl[i].e_pc));
            chk($sformatf("tbl%0d.l1_flush", i), 32'(bus.l1_flush), 32'(tbl[i].e_fl));
            chk($sformatf("tbl%0d.l2_bubble", i), 32'(bus.l2_bubble), 32'(tbl[i].e_bub));
            chk($sformatf("tbl%0d.stall", i), 32'(bus.stall), 32'(tbl[i].e_st));
            chk($sformatf("tbl%0d.stall_cnt", i), 32'(bus.stall_cnt), 32'(tbl[i].e_scnt));
            chk($sformatf("tbl%0d.flush_cnt", i), 32'(bus.flush_cnt), 32'(tbl[i].e_fcnt));
            chk($sformatf("tbl%0d.state", i), 32'(dut.state_q), 32'(tbl[i].e_state));
            advance();
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            t = v(($urandom_range(99) == 0), ($urandom_range(9) < 7), $urandom_range(7),
                  $urandom_range(7), $urandom_range(1), $urandom_range(1), $urandom_range(1),
                  $urandom_range(7), ($urandom_range(7) == 0), 0, 0, 0, 0, 0, 0, 0);
            drive(t);
            check_model();
            advance();
        end

        // Stuck WB entry: permanent hazard on r0 trips the watchdog and saturates stall_cnt.
        t = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(t);
        check_model();
        advance();
        force dut.u_sb.wb_valid_q = 1'b1;
        wb_stuck = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            t = v(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            drive(t);
            check_model();
            if (i == 4) chk("wdog_before_limit", 32'(bus.wdog_err), 32'd0);
            if (i == 5) chk("wdog_after_limit", 32'(bus.wdog_err), 32'd1);
            advance();
        end
        chk("wdog_sticky", 32'(bus.wdog_err), 32'd1);
        chk("stall_cnt_sat", 32'(bus.stall_cnt), 32'hFFFF);

        t = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(t);
        release dut.u_sb.wb_valid_q;
        check_model();
        advance();
        t = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(t);
        check_model();
        chk("wdog_cleared", 32'(bus.wdog_err), 32'd0);
        chk("stall_cnt_cleared", 32'(bus.stall_cnt), 32'd0);
        advance();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
